// File: rtl/playback_replay.sv
// Vector playback/replay engine: streams {flag, stimulus, expected} records from a
// vector store into a DUT, compares masked responses and reports error status.
module playback_replay #(
  parameter int unsigned IN_W         = 269,
  parameter int unsigned OUT_W        = 198,
  parameter int unsigned AW           = 12,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic                    rclk,
  input  logic                    arst_l,
  input  logic                    start,
  input  logic                    abort,
  input  logic [AW:0]             num_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    vec_rd_en,
  output logic [AW-1:0]           vec_rd_addr,
  input  logic [IN_W+OUT_W:0]     vec_rd_data,
  output logic [IN_W-1:0]         dut_in,
  output logic                    dut_step,
  input  logic [OUT_W-1:0]        dut_out,
  input  logic [OUT_W-1:0]        chk_mask,
  output logic [15:0]             err_cnt,
  output logic                    first_err_vld,
  output logic [AW-1:0]           first_err_idx
);

  localparam int unsigned FLAG_BIT = IN_W + OUT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       num_q, num_d;
  logic              v1_q, v1_d;
  logic [AW-1:0]     idx1_q, idx1_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [AW-1:0]     step_idx_q, step_idx_d;

  logic              busy_d, done_d, pass_d, rd_en_d, step_d, fvld_d;
  logic [AW-1:0]     rd_addr_d, fidx_d;
  logic [IN_W-1:0]   dut_in_d;
  logic [15:0]       err_cnt_d;

  logic              rec_flag;
  logic [IN_W-1:0]   rec_in;
  logic [OUT_W-1:0]  rec_exp;
  logic              mismatch_c;
  logic              active_c;

  assign rec_flag   = vec_rd_data[FLAG_BIT];
  assign rec_in     = vec_rd_data[IN_W+OUT_W-1:OUT_W];
  assign rec_exp    = vec_rd_data[OUT_W-1:0];
  assign mismatch_c = dut_step && (|((dut_out ^ exp_q) & chk_mask));
  assign active_c   = (state_q == FETCH) || (state_q == RUN) || (state_q == DRAIN);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    busy_d     = busy;
    done_d     = done;
    pass_d     = pass;
    rd_en_d    = 1'b0;
    rd_addr_d  = vec_rd_addr;
    v1_d       = vec_rd_en;
    idx1_d     = vec_rd_en ? vec_rd_addr : idx1_q;
    dut_in_d   = dut_in;
    exp_d      = exp_q;
    step_d     = 1'b0;
    step_idx_d = step_idx_q;
    err_cnt_d  = err_cnt;
    fvld_d     = first_err_vld;
    fidx_d     = first_err_idx;

    // Apply a returned record; flag=0 records are consumed silently
    if (v1_q && rec_flag) begin
      dut_in_d   = rec_in;
      exp_d      = rec_exp;
      step_d     = 1'b1;
      step_idx_d = idx1_q;
    end

    if (mismatch_c) begin
      if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
      if (!first_err_vld) begin
        fvld_d = 1'b1;
        fidx_d = step_idx_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          err_cnt_d = 16'd0;
          fvld_d    = 1'b0;
          fidx_d    = '0;
          if (num_vec == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d   = FETCH;
            num_d     = num_vec;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end
      FETCH: begin
        if (num_q == (AW+1)'(1)) begin
          state_d = DRAIN;
        end else begin
          state_d   = RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = AW'(1);
        end
      end
      RUN: begin
        if ({1'b0, vec_rd_addr} == num_q - (AW+1)'(1)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = vec_rd_addr + AW'(1);
        end
      end
      DRAIN: begin
        if (!vec_rd_en && !v1_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 16'd0);
        end
      end
      default: state_d = IDLE;
    endcase

    // Early termination drops everything still in flight
    if (active_c && (STOP_ON_FAIL != 0) && mismatch_c) begin
      state_d  = DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      pass_d   = 1'b0;
      rd_en_d  = 1'b0;
      v1_d     = 1'b0;
      step_d   = 1'b0;
      dut_in_d = dut_in;
      exp_d    = exp_q;
    end

    if (active_c && abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      rd_en_d   = 1'b0;
      v1_d      = 1'b0;
      step_d    = 1'b0;
      dut_in_d  = dut_in;
      exp_d     = exp_q;
      err_cnt_d = err_cnt;
      fvld_d    = first_err_vld;
      fidx_d    = first_err_idx;
    end
  end

  // State and output registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q       <= IDLE;
      num_q         <= '0;
      v1_q          <= 1'b0;
      idx1_q        <= '0;
      exp_q         <= '0;
      step_idx_q    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_rd_en     <= 1'b0;
      vec_rd_addr   <= '0;
      dut_in        <= '0;
      dut_step      <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      v1_q          <= v1_d;
      idx1_q        <= idx1_d;
      exp_q         <= exp_d;
      step_idx_q    <= step_idx_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      vec_rd_en     <= rd_en_d;
      vec_rd_addr   <= rd_addr_d;
      dut_in        <= dut_in_d;
      dut_step      <= step_d;
      err_cnt       <= err_cnt_d;
      first_err_vld <= fvld_d;
      first_err_idx <= fidx_d;
    end
  end

endmodule
